// File: rtl/vin_pattern_gen_pkg.sv
// rtl/vin_pattern_gen_pkg.sv - shared pattern mode encodings and reference video timings
package vin_pattern_gen_pkg;

  typedef enum logic [2:0] {
    MODE_WHITE   = 3'd0,
    MODE_BLACK   = 3'd1,
    MODE_HRAMP   = 3'd2,
    MODE_VRAMP   = 3'd3,
    MODE_CHECKER = 3'd4,
    MODE_SCROLL  = 3'd5
  } mode_e;

  // UXGA at 4 pixels per clock: horizontal values are in clocks, vertical in lines
  localparam int UXGA_H_FP   = 2;
  localparam int UXGA_H_SYNC = 8;
  localparam int UXGA_H_BP   = 10;
  localparam int UXGA_H_ACT  = 400;
  localparam int UXGA_V_FP   = 21;
  localparam int UXGA_V_SYNC = 8;
  localparam int UXGA_V_BP   = 6;
  localparam int UXGA_V_ACT  = 1200;

  localparam int SQCIF_H_FP   = 2;
  localparam int SQCIF_H_SYNC = 3;
  localparam int SQCIF_H_BP   = 4;
  localparam int SQCIF_H_ACT  = 32;
  localparam int SQCIF_V_FP   = 1;
  localparam int SQCIF_V_SYNC = 3;
  localparam int SQCIF_V_BP   = 6;
  localparam int SQCIF_V_ACT  = 96;

endpackage

// File: rtl/vin_pattern_lane.sv
// rtl/vin_pattern_lane.sv - one Y8 test-pattern pixel from its position, line and frame count
module vin_pattern_lane
  import vin_pattern_gen_pkg::*;
(
  input  logic [7:0] px,
  input  logic [7:0] y,
  input  logic [7:0] fcnt,
  input  logic [2:0] mode,
  output logic [7:0] pixel
);

  always_comb begin
    pixel = 8'hFF;
    case (mode)
      MODE_WHITE:   pixel = 8'hFF;
      MODE_BLACK:   pixel = 8'h00;
      MODE_HRAMP:   pixel = px;
      MODE_VRAMP:   pixel = y;
      MODE_CHECKER: pixel = (px[3] ^ y[3]) ? 8'hFF : 8'h00;
      MODE_SCROLL:  pixel = px + fcnt;
      default:      pixel = 8'hFF;
    endcase
  end

endmodule

// File: rtl/vin_pattern_gen.sv
// rtl/vin_pattern_gen.sv - raster timing generator with PPC-wide Y8 test patterns
module vin_pattern_gen
  import vin_pattern_gen_pkg::*;
#(
  parameter int PPC         = 4,
  parameter int CW          = 12,
  parameter int FCNT_MAX    = 480,
  parameter int DEF_H_FP    = UXGA_H_FP,
  parameter int DEF_H_SYNC  = UXGA_H_SYNC,
  parameter int DEF_H_BP    = UXGA_H_BP,
  parameter int DEF_H_ACT   = UXGA_H_ACT,
  parameter int DEF_V_FP    = UXGA_V_FP,
  parameter int DEF_V_SYNC  = UXGA_V_SYNC,
  parameter int DEF_V_BP    = UXGA_V_BP,
  parameter int DEF_V_ACT   = UXGA_V_ACT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CW-1:0]    cfg_h_fp,
  input  logic [CW-1:0]    cfg_h_sync,
  input  logic [CW-1:0]    cfg_h_bp,
  input  logic [CW-1:0]    cfg_h_act,
  input  logic [CW-1:0]    cfg_v_fp,
  input  logic [CW-1:0]    cfg_v_sync,
  input  logic [CW-1:0]    cfg_v_bp,
  input  logic [CW-1:0]    cfg_v_act,
  input  logic [2:0]       cfg_mode,
  output logic             v_pclk,
  output logic             v_hsync,
  output logic             v_vsync,
  output logic             v_de,
  output logic [8*PPC-1:0] v_pixel,
  output logic             frame_start
);

  localparam int TW = CW + 2;
  localparam int FW = (FCNT_MAX > 1) ? $clog2(FCNT_MAX) : 1;
  localparam logic [TW-1:0] TOT_MAX = TW'((64'd1 << CW) - 64'd1);
  localparam logic [FW-1:0] FC_LAST = FW'(FCNT_MAX - 1);

  function automatic logic [TW-1:0] ext(input logic [CW-1:0] v);
    return {2'b00, v};
  endfunction

  logic [CW-1:0] h_count, v_count;
  logic [FW-1:0] frame_count;
  logic [CW-1:0] h_fp_s, h_sync_s, h_bp_s, h_act_s;
  logic [CW-1:0] v_fp_s, v_sync_s, v_bp_s, v_act_s;
  logic [2:0]    mode_s;

  logic [TW-1:0] cfg_h_tot, cfg_v_tot;
  logic          cfg_ok, load_pt, use_cfg;

  assign v_pclk    = clk;
  assign cfg_h_tot = ext(cfg_h_fp) + ext(cfg_h_sync) + ext(cfg_h_bp) + ext(cfg_h_act);
  assign cfg_v_tot = ext(cfg_v_fp) + ext(cfg_v_sync) + ext(cfg_v_bp) + ext(cfg_v_act);
  assign cfg_ok    = (cfg_h_sync != '0) && (cfg_h_act != '0) &&
                     (cfg_v_sync != '0) && (cfg_v_act != '0) &&
                     (cfg_h_tot <= TOT_MAX) && (cfg_v_tot <= TOT_MAX);

  // The frame's first cycle already runs on the freshly loaded timing and mode
  assign load_pt = (h_count == '0) && (v_count == '0);
  assign use_cfg = load_pt && cfg_ok;

  logic [CW-1:0] h_fp_c, h_sync_c, h_bp_c, h_act_c;
  logic [CW-1:0] v_fp_c, v_sync_c, v_bp_c, v_act_c;
  logic [2:0]    mode_c;

  assign h_fp_c   = use_cfg ? cfg_h_fp   : h_fp_s;
  assign h_sync_c = use_cfg ? cfg_h_sync : h_sync_s;
  assign h_bp_c   = use_cfg ? cfg_h_bp   : h_bp_s;
  assign h_act_c  = use_cfg ? cfg_h_act  : h_act_s;
  assign v_fp_c   = use_cfg ? cfg_v_fp   : v_fp_s;
  assign v_sync_c = use_cfg ? cfg_v_sync : v_sync_s;
  assign v_bp_c   = use_cfg ? cfg_v_bp   : v_bp_s;
  assign v_act_c  = use_cfg ? cfg_v_act  : v_act_s;
  assign mode_c   = load_pt ? cfg_mode   : mode_s;

  logic [TW-1:0] hc, vc, h_sync_end, v_sync_end, h_blank, v_blank, h_tot, v_tot;
  logic          hs_d, vs_d, de_d, h_last, v_last;
  logic [7:0]    x8, y8, fcnt8;

  assign hc         = ext(h_count);
  assign vc         = ext(v_count);
  assign h_sync_end = ext(h_fp_c) + ext(h_sync_c);
  assign v_sync_end = ext(v_fp_c) + ext(v_sync_c);
  assign h_blank    = h_sync_end + ext(h_bp_c);
  assign v_blank    = v_sync_end + ext(v_bp_c);
  assign h_tot      = h_blank + ext(h_act_c);
  assign v_tot      = v_blank + ext(v_act_c);
  assign hs_d       = (hc >= ext(h_fp_c)) && (hc < h_sync_end);
  assign vs_d       = (vc >= ext(v_fp_c)) && (vc < v_sync_end);
  assign de_d       = (hc >= h_blank) && (vc >= v_blank);
  assign h_last     = (hc == h_tot - TW'(1));
  assign v_last     = (vc == v_tot - TW'(1));
  assign x8         = 8'(hc - h_blank);
  assign y8         = 8'(vc - v_blank);
  assign fcnt8      = 8'(frame_count);

  logic [8*PPC-1:0] pix_d;

  // Only the low byte of px = x*PPC+i is ever visible, so 8-bit arithmetic suffices
  for (genvar i = 0; i < PPC; i++) begin : g_lane
    logic [7:0] px;
    assign px = x8 * 8'(PPC) + 8'(i);
    vin_pattern_lane u_lane (
      .px   (px),
      .y    (y8),
      .fcnt (fcnt8),
      .mode (mode_c),
      .pixel(pix_d[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_count     <= '0;
      v_count     <= '0;
      frame_count <= '0;
      h_fp_s      <= CW'(DEF_H_FP);
      h_sync_s    <= CW'(DEF_H_SYNC);
      h_bp_s      <= CW'(DEF_H_BP);
      h_act_s     <= CW'(DEF_H_ACT);
      v_fp_s      <= CW'(DEF_V_FP);
      v_sync_s    <= CW'(DEF_V_SYNC);
      v_bp_s      <= CW'(DEF_V_BP);
      v_act_s     <= CW'(DEF_V_ACT);
      mode_s      <= '0;
      v_hsync     <= 1'b0;
      v_vsync     <= 1'b0;
      v_de        <= 1'b0;
      v_pixel     <= '0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      h_count     <= '0;
      v_count     <= '0;
      frame_count <= '0;
      v_hsync     <= 1'b0;
      v_vsync     <= 1'b0;
      v_de        <= 1'b0;
      v_pixel     <= '0;
      frame_start <= 1'b0;
    end else begin
      if (use_cfg) begin
        h_fp_s   <= cfg_h_fp;
        h_sync_s <= cfg_h_sync;
        h_bp_s   <= cfg_h_bp;
        h_act_s  <= cfg_h_act;
        v_fp_s   <= cfg_v_fp;
        v_sync_s <= cfg_v_sync;
        v_bp_s   <= cfg_v_bp;
        v_act_s  <= cfg_v_act;
      end
      if (load_pt) mode_s <= cfg_mode;
      v_hsync     <= hs_d;
      v_vsync     <= vs_d;
      v_de        <= de_d;
      v_pixel     <= de_d ? pix_d : '0;
      frame_start <= load_pt;
      if (h_last) begin
        h_count <= '0;
        if (v_last) begin
          v_count     <= '0;
          frame_count <= (frame_count == FC_LAST) ? '0 : frame_count + FW'(1);
        end else begin
          v_count <= v_count + CW'(1);
        end
      end else begin
        h_count <= h_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vin_pattern_gen.sv
// tb/tb_vin_pattern_gen.sv - directed, table-driven bench for vin_pattern_gen
module tb_vin_pattern_gen;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [11:0] cfg_h_fp, cfg_h_sync, cfg_h_bp, cfg_h_act;
  logic [11:0] cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_v_act;
  logic [2:0]  cfg_mode;
  logic        v_pclk, v_hsync, v_vsync, v_de, frame_start;
  logic [31:0] v_pixel;

  always #5 clk = ~clk;

  vin_pattern_gen #(.PPC(4), .CW(12), .FCNT_MAX(480)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp), .cfg_h_act(cfg_h_act),
    .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp), .cfg_v_act(cfg_v_act),
    .cfg_mode(cfg_mode), .v_pclk(v_pclk), .v_hsync(v_hsync), .v_vsync(v_vsync),
    .v_de(v_de), .v_pixel(v_pixel), .frame_start(frame_start)
  );

  typedef struct {
    int hf, hsy, hb, ha, vf, vsy, vb, va, md;
    int period, de_n, hs_n, vs_n;
    logic [31:0] px;
  } frame_vec_t;

  typedef struct {
    int hsy, ha, vsy, va, exp_next;
  } rej_vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int pos   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int hf, hsy, hb, ha, vf, vsy, vb, va, md);
    cfg_h_fp = 12'(hf);  cfg_h_sync = 12'(hsy); cfg_h_bp = 12'(hb); cfg_h_act = 12'(ha);
    cfg_v_fp = 12'(vf);  cfg_v_sync = 12'(vsy); cfg_v_bp = 12'(vb); cfg_v_act = 12'(va);
    cfg_mode = 3'(md);
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    pos += n;
  endtask

  task automatic goto(input int t);
    if (t > pos) adv(t - pos);
  endtask

  // Park the generator with enable low, then restart; leaves us on the frame_start sample
  task automatic start_frame(input int hf, hsy, hb, ha, vf, vsy, vb, va, md);
    enable = 1'b0;
    set_cfg(hf, hsy, hb, ha, vf, vsy, vb, va, md);
    @(negedge clk);
    check("disabled_zero", {v_hsync, v_vsync, v_de, frame_start, v_pixel}, 64'd0);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("fs_on_enable", frame_start, 1);
    pos = 0;
  endtask

  // Count from the current sample up to (not including) the next frame_start sample
  task automatic measure(input logic [31:0] exp_px, output int cyc, output int de_n,
                         output int hs_n, output int vs_n, output int bad);
    cyc = 0; de_n = 0; hs_n = 0; vs_n = 0; bad = 0;
    do begin
      de_n += int'(v_de);
      hs_n += int'(v_hsync);
      vs_n += int'(v_vsync);
      if (v_de ? (v_pixel !== exp_px) : (v_pixel !== 32'd0)) bad++;
      cyc++;
      @(negedge clk);
    end while (!frame_start && cyc < 20000);
    pos = 0;
  endtask

  frame_vec_t fv[4];
  rej_vec_t   rv[4];

  initial begin
    int cyc, de_n, hs_n, vs_n, bad, n;
    logic [7:0] fc;

    fv[0] = '{2, 3, 4, 32, 1, 3, 6, 96, 0, 4346, 3072, 318, 123, 32'hFFFFFFFF};
    fv[1] = '{1, 2, 1, 8,  1, 1, 1, 4,  1, 84,   32,   14,  12,  32'h00000000};
    fv[2] = '{0, 1, 0, 4,  0, 2, 0, 3,  6, 25,   12,   5,   10,  32'hFFFFFFFF};
    fv[3] = '{3, 1, 2, 5,  2, 2, 1, 2,  7, 77,   10,   7,   22,  32'hFFFFFFFF};

    rv[0] = '{3, 32,   3, 0,  4346};
    rv[1] = '{0, 32,   3, 96, 4346};
    rv[2] = '{3, 4090, 3, 96, 4346};
    rv[3] = '{3, 16,   3, 96, 2650};

    rst = 1'b1;
    enable = 1'b1;
    set_cfg(2, 3, 4, 32, 1, 3, 6, 96, 0);
    repeat (3) @(negedge clk);
    check("reset_outputs", {v_hsync, v_vsync, v_de, frame_start, v_pixel}, 64'd0);
    check("pclk_low", v_pclk, 0);
    @(posedge clk);
    #1;
    check("pclk_high", v_pclk, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 4; r++) begin
      start_frame(fv[r].hf, fv[r].hsy, fv[r].hb, fv[r].ha,
                  fv[r].vf, fv[r].vsy, fv[r].vb, fv[r].va, fv[r].md);
      measure(fv[r].px, cyc, de_n, hs_n, vs_n, bad);
      check($sformatf("row%0d_period", r), cyc, fv[r].period);
      check($sformatf("row%0d_de", r), de_n, fv[r].de_n);
      check($sformatf("row%0d_hsync", r), hs_n, fv[r].hs_n);
      check($sformatf("row%0d_vsync", r), vs_n, fv[r].vs_n);
      check($sformatf("row%0d_pixels", r), bad, 0);
    end

    // Horizontal ramp on an 80-clock active line so x reaches 64
    start_frame(2, 3, 4, 80, 1, 3, 6, 96, 2);
    goto(898); check("hramp_pre_de", {v_de, v_pixel}, {1'b0, 32'h0});
    goto(899); check("hramp_x0",  {v_de, v_pixel}, {1'b1, 32'h03020100});
    goto(900); check("hramp_x1",  {v_de, v_pixel}, {1'b1, 32'h07060504});
    goto(962); check("hramp_x63", {v_de, v_pixel}, {1'b1, 32'hFFFEFDFC});
    goto(963); check("hramp_x64", {v_de, v_pixel}, {1'b1, 32'h03020100});
    goto(978); check("hramp_x79", {v_de, v_pixel}, {1'b1, 32'h3F3E3D3C});
    goto(979); check("hramp_eol", {v_de, v_pixel}, {1'b0, 32'h0});

    // Vertical ramp; a mode change mid-frame waits for the next frame
    start_frame(0, 1, 0, 8, 0, 1, 0, 20, 3);
    cfg_mode = 3'd0;
    goto(55);  check("vramp_y5",    {v_de, v_pixel}, {1'b1, 32'h05050505});
    goto(188); check("vramp_y19",   {v_de, v_pixel}, {1'b1, 32'h13131313});
    goto(189); check("next_fs",     frame_start, 1);
    goto(199); check("mode_next_frame", {v_de, v_pixel}, {1'b1, 32'hFFFFFFFF});

    start_frame(0, 1, 0, 8, 0, 1, 0, 20, 4);
    goto(11); check("checker_y0_x1", {v_de, v_pixel}, {1'b1, 32'h00000000});
    goto(12); check("checker_y0_x2", {v_de, v_pixel}, {1'b1, 32'hFFFFFFFF});
    goto(82); check("checker_y8_x0", {v_de, v_pixel}, {1'b1, 32'hFFFFFFFF});
    goto(84); check("checker_y8_x2", {v_de, v_pixel}, {1'b1, 32'h00000000});

    // Mid-frame config updates: invalid ones never take effect, valid one waits for the wrap
    start_frame(2, 3, 4, 32, 1, 3, 6, 96, 0);
    for (int r = 0; r < 4; r++) begin
      goto(1000);
      set_cfg(2, rv[r].hsy, 4, rv[r].ha, 1, rv[r].vsy, 6, rv[r].va, 0);
      measure(32'hFFFFFFFF, cyc, de_n, hs_n, vs_n, bad);
      check($sformatf("cfg%0d_remainder", r), cyc, 3346);
      measure(32'hFFFFFFFF, cyc, de_n, hs_n, vs_n, bad);
      check($sformatf("cfg%0d_next_frame", r), cyc, rv[r].exp_next);
    end

    // Reset in the middle of a frame
    start_frame(2, 3, 4, 32, 1, 3, 6, 96, 0);
    goto(50 * 41 + 20);
    rst = 1'b1;
    adv(1);
    check("rst_outputs_zero", {v_hsync, v_vsync, v_de, frame_start, v_pixel}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("fs_after_rst", {frame_start, v_de}, 2'b10);
    n = 1;
    while (!v_de && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("first_de_after_rst", n, 420);

    // Scrolling ramp over a full frame-counter period on a 2x2 raster
    start_frame(0, 1, 0, 1, 0, 1, 0, 1, 5);
    for (int f = 0; f <= 480; f++) begin
      goto(f * 4 + 3);
      fc = 8'(f % 480);
      check($sformatf("scroll_f%0d", f), {v_de, v_pixel},
            {1'b1, 8'(fc + 8'd3), 8'(fc + 8'd2), 8'(fc + 8'd1), fc});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/vin_pattern_gen.md
VIN_PATTERN_GEN -- requirements
Module: vin_pattern_gen

Interface
REQ-001 Parameter PPC, default 4: pixels per clock; each pixel is Y8.
REQ-002 Parameter CW, default 12: width of the timing counters and config fields.
REQ-003 Parameter FCNT_MAX, default 480: frame counter modulus.
REQ-004 Parameters DEF_H_FP/H_SYNC/H_BP/H_ACT, defaults 2/8/10/400: reset timing in clocks.
REQ-005 Parameters DEF_V_FP/V_SYNC/V_BP/V_ACT, defaults 21/8/6/1200: reset timing in lines.
REQ-006 Port clk, input, 1: system clock; the only clock.
REQ-007 Port rst, input, 1: reset; one clock; reset is synchronous and active-high.
REQ-008 Port enable, input, 1: run the generator when high.
REQ-009 Ports cfg_h_fp, cfg_h_sync, cfg_h_bp, cfg_h_act, input, CW each: requested horizontal timing.
REQ-010 Ports cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_v_act, input, CW each: requested vertical timing.
REQ-011 Port cfg_mode, input, 3: pattern select.
REQ-012 Port v_pclk, output, 1: equals clk.
REQ-013 Ports v_hsync, v_vsync, v_de, output, 1 each: active-high, registered.
REQ-014 Port v_pixel, output, 8*PPC: pixel i occupies bits [8i+7:8i]; pixel 0 is leftmost.
REQ-015 Port frame_start, output, 1: one-cycle pulse with the first cycle of each frame.

Function
REQ-016 h_count SHALL run 0..H_TOTAL-1 and wrap; v_count SHALL advance on each h wrap and wrap at V_TOTAL-1. TOTAL = FP+SYNC+BP+ACT.
REQ-017 Line layout, in order: FP, SYNC, BP, ACT. hs = h_count in [FP, FP+SYNC-1]; vs uses the same rule on v_count.
REQ-018 de = (h_count >= H_BLANK) and (v_count >= V_BLANK); x = h_count-H_BLANK and y = v_count-V_BLANK while de, else 0.
REQ-019 All outputs SHALL be registered: exactly one clock of latency from counter state to outputs, with hsync, vsync, de and pixel aligned.
REQ-020 Active timing SHALL come from shadow registers that load from cfg_* only on the cycle where both counters wrap to 0.
REQ-021 A config with any SYNC or ACT field equal to 0, or any TOTAL above 2^CW-1, SHALL be rejected at the load point; the previous shadow values are kept.
REQ-022 frame_count SHALL increment at each frame wrap, modulo FCNT_MAX.
REQ-023 Pixel value per lane, with px = x*PPC+i, 8-bit results truncated:
- mode 0: 0xFF
- mode 1: 0x00
- mode 2: px[7:0]
- mode 3: y[7:0]
- mode 4: 0xFF if px[3]^y[3], else 0x00
- mode 5: (px+frame_count)[7:0]
- modes 6 and 7: 0xFF
REQ-024 v_pixel SHALL be 0 when de is low.
REQ-025 cfg_mode SHALL be sampled at frame wrap, so the pattern never changes mid-frame.
REQ-026 When enable is low, counters SHALL hold at 0 and all outputs SHALL be 0.
REQ-027 When enable rises, the first cycle SHALL be frame start with h=0, v=0, and the shadow load applies on that cycle.
REQ-028 frame_start SHALL be registered and asserted in the cycle whose outputs correspond to h=0, v=0.

Reset
REQ-029 On rst, h_count, v_count, frame_count and all outputs SHALL go to 0, the shadow registers to the DEF_* values, and the mode shadow to 0.
REQ-030 rst asserted mid-frame SHALL abort the frame; the next frame starts at h=0, v=0 on the first cycle after deassertion, provided enable is high.

Structure
REQ-031 A shared package SHALL hold the mode encodings (MODE_WHITE..MODE_SCROLL) and the default timing constants for UXGA and SQCIF.
REQ-032 One sub-module, vin_pattern_lane, SHALL compute a single Y8 pixel from (px, y, frame_count, mode); it is instantiated PPC times through generate.
REQ-033 Expected size: 150-300 lines of RTL.

Verification
REQ-034 SQCIF config (H 2/3/4/32, V 1/3/6/96), mode 0, PPC=4 -> line period 41 clks, frame 4346 clks, 3072 de cycles per frame, hsync 3 clks per line, vsync 123 clks per frame, v_pixel=0xFFFFFFFF during de.
REQ-035 Mode 2 -> first active word 0x03020100, word 63 (x=63) 0xFFFEFDFC, x=64 wraps to 0x03020100.
REQ-036 Change cfg_h_act 32->16 mid-frame -> current frame keeps 41-clk lines; the next frame uses 25-clk lines from its first cycle.
REQ-037 cfg_v_act=0 presented at wrap -> rejected; timing stays 4346 clks per frame.
REQ-038 rst pulsed at h=20, v=50 -> outputs 0 the next cycle; after release, frame_start occurs on the first cycle of the new frame, and the first de arrives 10*41+9+1 clocks later.
REQ-039 Mode 5 over FCNT_MAX=480 frames -> lane-0 value at x=0, y=0 equals frame_count mod 256 and wraps to 0 after frame 479.
